// File: rtl/bp_fe_gshare_pkg.sv
// Shared types for the gshare sequencer: FSM states and the buffered update record.
// The update record width follows bht_idx_width_gp, which the top uses as its default index width.
package bp_fe_gshare_pkg;

  localparam int bht_idx_width_gp = 9;

  typedef enum logic {
    e_idle = 1'b0,
    e_resp = 1'b1
  } bp_gshare_state_e;

  typedef struct packed {
    logic [bht_idx_width_gp-1:0] idx;
    logic                        correct;
  } bp_gshare_upd_s;

endpackage

// File: rtl/bp_fe_gshare_upd_fifo.sv
// 1r1w queue of BHT training updates; data out is the head, valid while non-empty.
// ready_o comes straight from a registered full flag, so a same-cycle dequeue never frees a slot early.
module bp_fe_gshare_upd_fifo
  import bp_fe_gshare_pkg::*;
#(
  parameter int els_p = 2
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           v_i,
  input  bp_gshare_upd_s data_i,
  output logic           ready_o,
  output logic           v_o,
  output bp_gshare_upd_s data_o,
  input  logic           yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  bp_gshare_upd_s          mem_r [els_p];
  logic [ptr_w_lp-1:0]     wptr_r, rptr_r;
  logic [cnt_w_lp-1:0]     cnt_r, cnt_n;
  logic                    full_r, empty_r;
  logic                    enq, deq;

  assign ready_o = !full_r;
  assign v_o     = !empty_r;
  assign data_o  = mem_r[rptr_r];
  assign enq     = v_i && !full_r;
  assign deq     = yumi_i && !empty_r;

  always_comb begin
    cnt_n = cnt_r;
    if (enq && !deq)      cnt_n = cnt_r + 1'b1;
    else if (!enq && deq) cnt_n = cnt_r - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      cnt_r   <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (enq) wptr_r <= (wptr_r == ptr_w_lp'(els_p - 1)) ? '0 : wptr_r + 1'b1;
      if (deq) rptr_r <= (rptr_r == ptr_w_lp'(els_p - 1)) ? '0 : rptr_r + 1'b1;
      cnt_r   <= cnt_n;
      full_r  <= (cnt_n == cnt_w_lp'(els_p));
      empty_r <= (cnt_n == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_fe_bp_gshare_ctrl.sv
// Sequences fetch lookups and queued training writes onto a single-ported gshare BHT.
// Owns the global history: shifts in each prediction, restores from the backend snapshot on mispredict.
module bp_fe_bp_gshare_ctrl
  import bp_fe_gshare_pkg::*;
#(
  parameter int bht_idx_width_p   = bht_idx_width_gp,
  parameter int bp_cnt_sat_bits_p = 2,
  parameter int vaddr_width_p     = 39,
  parameter int upd_fifo_els_p    = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       fetch_v_i,
  input  logic [vaddr_width_p-1:0]   fetch_pc_i,
  output logic                       fetch_ready_o,
  output logic                       pred_v_o,
  output logic                       pred_taken_o,
  output logic [bht_idx_width_p-1:0] pred_idx_o,
  output logic [bht_idx_width_p-1:0] pred_ghr_o,
  input  logic                       upd_v_i,
  input  logic [bht_idx_width_p-1:0] upd_idx_i,
  input  logic                       upd_correct_i,
  input  logic                       upd_taken_i,
  input  logic [bht_idx_width_p-1:0] upd_ghr_i,
  output logic                       upd_ready_o,
  output logic                       bp_r_v_o,
  output logic [bht_idx_width_p-1:0] bp_idx_r_o,
  input  logic                       bp_predict_i,
  output logic                       bp_w_v_o,
  output logic [bht_idx_width_p-1:0] bp_idx_w_o,
  output logic                       bp_correct_o
);

  localparam int w_lp = bht_idx_width_p;

  bp_gshare_state_e     state_r, state_n;
  logic [w_lp-1:0]      ghr_r, ghr_n;
  logic [w_lp-1:0]      pred_idx_r, pred_ghr_r;
  logic [w_lp-1:0]      lookup_idx;
  logic                 fetch_acc, upd_acc, repair;
  logic                 fifo_ready, fifo_v;
  bp_gshare_upd_s       fifo_din, fifo_dout;
  logic                 unused_bits;

  assign unused_bits = ^{fetch_pc_i[vaddr_width_p-1:w_lp+2], fetch_pc_i[1:0], upd_ghr_i[w_lp-1]};

  assign lookup_idx = fetch_pc_i[w_lp+1:2] ^ ghr_r;
  assign fetch_acc  = fetch_v_i && fetch_ready_o;

  assign upd_ready_o = fifo_ready && !reset_i;
  assign upd_acc     = upd_v_i && upd_ready_o;
  assign repair      = upd_acc && !upd_correct_i;
  assign fifo_din    = '{idx: upd_idx_i, correct: upd_correct_i};

  bp_fe_gshare_upd_fifo #(.els_p(upd_fifo_els_p)) upd_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (upd_acc),
    .data_i (fifo_din),
    .ready_o(fifo_ready),
    .v_o    (fifo_v),
    .data_o (fifo_dout),
    .yumi_i (bp_w_v_o)
  );

  // Reads win the port; a full queue blocks fetch so the pending write gets a free slot.
  always_comb begin
    state_n       = state_r;
    fetch_ready_o = 1'b0;
    pred_v_o      = 1'b0;
    if (!reset_i) begin
      case (state_r)
        e_idle: begin
          fetch_ready_o = fifo_ready;
          if (fetch_v_i && fifo_ready) state_n = e_resp;
        end
        e_resp: begin
          pred_v_o = !repair;
          state_n  = e_idle;
        end
        default: state_n = e_idle;
      endcase
    end
  end

  assign bp_r_v_o     = fetch_acc;
  assign bp_idx_r_o   = fetch_acc ? lookup_idx : '0;
  assign bp_w_v_o     = !reset_i && !fetch_acc && fifo_v;
  assign bp_idx_w_o   = bp_w_v_o ? fifo_dout.idx : '0;
  assign bp_correct_o = bp_w_v_o && fifo_dout.correct;

  assign pred_taken_o = pred_v_o && bp_predict_i;
  assign pred_idx_o   = reset_i ? '0 : pred_idx_r;
  assign pred_ghr_o   = reset_i ? '0 : pred_ghr_r;

  always_comb begin
    ghr_n = ghr_r;
    if (repair)                ghr_n = {upd_ghr_i[w_lp-2:0], upd_taken_i};
    else if (state_r == e_resp) ghr_n = {ghr_r[w_lp-2:0], bp_predict_i};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_idle;
      ghr_r      <= '0;
      pred_idx_r <= '0;
      pred_ghr_r <= '0;
    end else begin
      state_r <= state_n;
      ghr_r   <= ghr_n;
      if (fetch_acc) begin
        pred_idx_r <= lookup_idx;
        pred_ghr_r <= ghr_r;
      end
    end
  end

  a_one_bht_op: assert property (@(posedge clk_i) !(bp_r_v_o && bp_w_v_o));
  a_cfg: assert property (@(posedge clk_i) (bp_cnt_sat_bits_p > 0) && (upd_fifo_els_p >= 2));

endmodule

// File: tb/tb_bp_fe_bp_gshare_ctrl.sv
// Directed scenarios plus a randomized run scored against a rule-level model of the gshare sequencer.
module tb_bp_fe_bp_gshare_ctrl;

  localparam int W = 9;

  logic         clk = 1'b0, reset = 1'b1;
  logic         fetch_v, fetch_ready, pred_v, pred_taken;
  logic [38:0]  fetch_pc;
  logic [W-1:0] pred_idx, pred_ghr, upd_idx, upd_ghr, bp_idx_r, bp_idx_w;
  logic         upd_v, upd_correct, upd_taken, upd_ready;
  logic         bp_r_v, bp_predict, bp_w_v, bp_correct;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bp_fe_bp_gshare_ctrl dut (
    .clk_i(clk), .reset_i(reset),
    .fetch_v_i(fetch_v), .fetch_pc_i(fetch_pc), .fetch_ready_o(fetch_ready),
    .pred_v_o(pred_v), .pred_taken_o(pred_taken), .pred_idx_o(pred_idx), .pred_ghr_o(pred_ghr),
    .upd_v_i(upd_v), .upd_idx_i(upd_idx), .upd_correct_i(upd_correct), .upd_taken_i(upd_taken),
    .upd_ghr_i(upd_ghr), .upd_ready_o(upd_ready),
    .bp_r_v_o(bp_r_v), .bp_idx_r_o(bp_idx_r), .bp_predict_i(bp_predict),
    .bp_w_v_o(bp_w_v), .bp_idx_w_o(bp_idx_w), .bp_correct_o(bp_correct)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [38:0] pc, input logic uv, input logic [W-1:0] uidx,
                       input logic uc, input logic ut, input logic [W-1:0] ughr, input logic pred);
    fetch_v = fv; fetch_pc = pc; upd_v = uv; upd_idx = uidx;
    upd_correct = uc; upd_taken = ut; upd_ghr = ughr; bp_predict = pred;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, '0, 0, '0, 1, 0, '0, 0);
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 39'h40C, 1, '0, 1, 0, '0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      #3;
      checks++; if (bp_r_v !== 1'b0) begin errors++; $display("FAIL reset_rv: got %0b expected 0", bp_r_v); end
      checks++; if (fetch_ready !== 1'b0 || upd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b/%0b expected 0/0", fetch_ready, upd_ready); end
      checks++; if (pred_v !== 1'b0 || bp_w_v !== 1'b0) begin errors++; $display("FAIL reset_outs: got %0b/%0b expected 0/0", pred_v, bp_w_v); end
      tick();
    end
    reset = 1'b0;
    upd_v = 1'b0;
    #3;
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b expected 1", fetch_ready); end
    tick();
  endtask

  task automatic test_index();
    do_reset();
    drive(1, 39'h40C, 0, '0, 1, 0, '0, 0);
    #3;
    checks++; if (bp_r_v !== 1'b1 || bp_idx_r !== 9'h103) begin errors++; $display("FAIL index_read: got v=%0b idx=%0h expected v=1 idx=103", bp_r_v, bp_idx_r); end
    tick();
    drive(0, '0, 0, '0, 1, 0, '0, 1);
    #3;
    checks++; if (pred_v !== 1'b1 || pred_taken !== 1'b1) begin errors++; $display("FAIL index_pred: got v=%0b t=%0b expected 1/1", pred_v, pred_taken); end
    checks++; if (pred_idx !== 9'h103 || pred_ghr !== 9'h000) begin errors++; $display("FAIL index_meta: got idx=%0h ghr=%0h expected 103/0", pred_idx, pred_ghr); end
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL index_resp_ready: got %0b expected 0", fetch_ready); end
    tick();
    drive(1, '0, 0, '0, 1, 0, '0, 0);
    #3;
    checks++; if (bp_idx_r !== 9'h001) begin errors++; $display("FAIL index_ghr_shift: got %0h expected 1", bp_idx_r); end
    tick();
    drive(0, '0, 0, '0, 1, 0, '0, 0);
    #3;
    checks++; if (pred_ghr !== 9'h001) begin errors++; $display("FAIL index_pred_ghr: got %0h expected 1", pred_ghr); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] g;
    logic [38:0]  pc;
    logic         p;
    int           accepts;
    g = '0; accepts = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      pc = 39'({$urandom(), $urandom()});
      p  = 1'($urandom_range(0, 1));
      drive(1, pc, 0, '0, 1, 0, '0, p);
      #3;
      checks++; if (bp_r_v !== (i % 2 == 0)) begin errors++; $display("FAIL b2b_rv[%0d]: got %0b expected %0b", i, bp_r_v, (i % 2 == 0)); end
      if (i % 2 == 0) begin
        checks++; if (bp_idx_r !== (pc[W+1:2] ^ g)) begin errors++; $display("FAIL b2b_idx[%0d]: got %0h expected %0h", i, bp_idx_r, pc[W+1:2] ^ g); end
      end else begin
        checks++; if (pred_v !== 1'b1 || pred_taken !== p) begin errors++; $display("FAIL b2b_pred[%0d]: got %0b/%0b expected 1/%0b", i, pred_v, pred_taken, p); end
        g = {g[W-2:0], p};
      end
      if (bp_r_v === 1'b1) accepts++;
      tick();
    end
    checks++; if (accepts != 3) begin errors++; $display("FAIL b2b_accepts: got %0d expected 3", accepts); end
    drive(1, '0, 0, '0, 1, 0, '0, 0);
    #3;
    checks++; if (bp_idx_r !== g) begin errors++; $display("FAIL b2b_final_ghr: got %0h expected %0h", bp_idx_r, g); end
    tick();
    drive(0, '0, 0, '0, 1, 0, '0, 0);
    tick();
  endtask

  task automatic test_queue_full();
    logic [W-1:0] qi[$];
    logic         qc[$];
    logic [W-1:0] ui;
    logic         uc, e_ur, e_wv;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ui = W'($urandom());
      uc = 1'($urandom_range(0, 1));
      drive(i < 8, 39'($urandom()), i < 8, ui, uc, 1'($urandom_range(0, 1)), W'($urandom()), 1'($urandom_range(0, 1)));
      e_ur = (i < 3) || (i % 2 == 0);
      e_wv = (i % 2 == 1) || (i == 8);
      #3;
      checks++; if (bp_r_v !== (i % 2 == 0 && i < 8)) begin errors++; $display("FAIL qfull_rv[%0d]: got %0b expected %0b", i, bp_r_v, (i % 2 == 0 && i < 8)); end
      checks++; if (bp_w_v !== e_wv) begin errors++; $display("FAIL qfull_wv[%0d]: got %0b expected %0b", i, bp_w_v, e_wv); end
      checks++; if (bp_r_v === 1'b1 && bp_w_v === 1'b1) begin errors++; $display("FAIL qfull_both[%0d]: got 1 expected 0", i); end
      if (i < 8) begin
        checks++; if (upd_ready !== e_ur) begin errors++; $display("FAIL qfull_urdy[%0d]: got %0b expected %0b", i, upd_ready, e_ur); end
      end
      if (e_wv && qi.size() > 0) begin
        checks++; if (bp_idx_w !== qi[0] || bp_correct !== qc[0]) begin errors++; $display("FAIL qfull_order[%0d]: got %0h/%0b expected %0h/%0b", i, bp_idx_w, bp_correct, qi[0], qc[0]); end
        void'(qi.pop_front()); void'(qc.pop_front());
      end
      if (i < 8 && e_ur) begin qi.push_back(ui); qc.push_back(uc); end
      tick();
    end
    checks++; if (qi.size() != 0) begin errors++; $display("FAIL qfull_drained: got %0d left expected 0", qi.size()); end
  endtask

  task automatic test_repair();
    do_reset();
    drive(1, '0, 0, '0, 1, 0, '0, 0);
    tick();
    drive(0, '0, 1, 9'h011, 0, 1, 9'h0AA, 1);
    #3;
    checks++; if (pred_v !== 1'b0) begin errors++; $display("FAIL repair_pred_v: got %0b expected 0", pred_v); end
    tick();
    drive(1, '0, 0, '0, 1, 0, '0, 0);
    #3;
    checks++; if (bp_r_v !== 1'b1 || bp_idx_r !== 9'h155) begin errors++; $display("FAIL repair_ghr: got v=%0b idx=%0h expected v=1 idx=155", bp_r_v, bp_idx_r); end
    tick();
    drive(0, '0, 1, 9'h022, 1, 1, 9'h1FF, 0);
    #3;
    checks++; if (pred_v !== 1'b1 || pred_ghr !== 9'h155) begin errors++; $display("FAIL repair_resp: got v=%0b ghr=%0h expected 1/155", pred_v, pred_ghr); end
    tick();
    drive(1, '0, 0, '0, 1, 0, '0, 0);
    #3;
    checks++; if (bp_idx_r !== 9'h0AA) begin errors++; $display("FAIL correct_no_repair: got %0h expected 0aa", bp_idx_r); end
    tick();
    drive(0, '0, 0, '0, 1, 0, '0, 0);
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_resp();
    int wcount;
    wcount = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 39'($urandom()), 1, W'($urandom()), 1, 0, '0, 1);
      tick();
    end
    reset = 1'b1;
    drive(0, '0, 0, '0, 1, 0, '0, 1);
    #3;
    checks++; if (bp_w_v !== 1'b0 || pred_v !== 1'b0) begin errors++; $display("FAIL rstresp_outs: got w=%0b p=%0b expected 0/0", bp_w_v, pred_v); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #3;
      if (bp_w_v === 1'b1) wcount++;
      tick();
    end
    checks++; if (wcount != 0) begin errors++; $display("FAIL rstresp_flush: got %0d writes expected 0", wcount); end
    drive(1, '0, 0, '0, 1, 0, '0, 0);
    #3;
    checks++; if (fetch_ready !== 1'b1 || bp_idx_r !== 9'h000) begin errors++; $display("FAIL rstresp_ghr: got rdy=%0b idx=%0h expected 1/0", fetch_ready, bp_idx_r); end
    tick();
    drive(0, '0, 0, '0, 1, 0, '0, 0);
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] m_ghr, m_pidx, m_pghr, old_ghr, e_ridx;
    logic         m_resp;
    logic [W-1:0] qi[$];
    logic         qc[$];
    logic         fv, uv, uc, ut, pr, full, e_fr, acc, e_wv, uacc, rep, e_pv;
    logic [38:0]  pc;
    logic [W-1:0] ui, ug;
    m_ghr = '0; m_pidx = '0; m_pghr = '0; m_resp = 1'b0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      fv = ($urandom_range(0, 3) != 0);
      pc = 39'({$urandom(), $urandom()});
      uv = ($urandom_range(0, 2) == 0);
      ui = W'($urandom());
      uc = ($urandom_range(0, 3) != 0);
      ut = 1'($urandom_range(0, 1));
      ug = W'($urandom());
      pr = 1'($urandom_range(0, 1));
      drive(fv, pc, uv, ui, uc, ut, ug, pr);
      full   = (qi.size() == 2);
      e_fr   = !m_resp && !full;
      acc    = fv && e_fr;
      e_ridx = pc[W+1:2] ^ m_ghr;
      e_wv   = !acc && (qi.size() > 0);
      uacc   = uv && !full;
      rep    = uacc && !uc;
      e_pv   = m_resp && !rep;
      #3;
      checks++; if (fetch_ready !== e_fr || bp_r_v !== acc) begin errors++; $display("FAIL rnd_fetch[%0d]: got rdy=%0b rv=%0b expected %0b/%0b", c, fetch_ready, bp_r_v, e_fr, acc); end
      if (acc) begin
        checks++; if (bp_idx_r !== e_ridx) begin errors++; $display("FAIL rnd_ridx[%0d]: got %0h expected %0h", c, bp_idx_r, e_ridx); end
      end
      checks++; if (bp_w_v !== e_wv || upd_ready !== !full) begin errors++; $display("FAIL rnd_wv[%0d]: got wv=%0b urdy=%0b expected %0b/%0b", c, bp_w_v, upd_ready, e_wv, !full); end
      if (e_wv) begin
        checks++; if (bp_idx_w !== qi[0] || bp_correct !== qc[0]) begin errors++; $display("FAIL rnd_write[%0d]: got %0h/%0b expected %0h/%0b", c, bp_idx_w, bp_correct, qi[0], qc[0]); end
        void'(qi.pop_front()); void'(qc.pop_front());
      end
      checks++; if (pred_v !== e_pv || pred_taken !== (e_pv && pr)) begin errors++; $display("FAIL rnd_pred[%0d]: got %0b/%0b expected %0b/%0b", c, pred_v, pred_taken, e_pv, e_pv && pr); end
      if (e_pv) begin
        checks++; if (pred_idx !== m_pidx || pred_ghr !== m_pghr) begin errors++; $display("FAIL rnd_meta[%0d]: got %0h/%0h expected %0h/%0h", c, pred_idx, pred_ghr, m_pidx, m_pghr); end
      end
      if (uacc) begin qi.push_back(ui); qc.push_back(uc); end
      old_ghr = m_ghr;
      if (rep)         m_ghr = {ug[W-2:0], ut};
      else if (m_resp) m_ghr = {m_ghr[W-2:0], pr};
      if (acc) begin m_pidx = e_ridx; m_pghr = old_ghr; end
      m_resp = acc;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_index();
    test_back_to_back();
    test_queue_full();
    test_repair();
    test_reset_mid_resp();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
